// File: rtl/control_pipe.sv
// Pipeline control stager and hazard unit for the five-stage MIPS datapath.
// Carries the decoded control bundle through ID/EX, EX/MEM and MEM/WB, and
// produces load-use stalls, branch/jump flushes and EX-stage forwarding selects.
module control_pipe #(
    parameter int RW = 5
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          RegDst_i,
    input  logic          ALUSrc_i,
    input  logic          MemToReg_i,
    input  logic          RegWrite_i,
    input  logic          MemWrite_i,
    input  logic          MemRead_i,
    input  logic          Branch_i,
    input  logic          Jump_i,
    input  logic [1:0]    ALUOp_i,
    input  logic [RW-1:0] rs_i,
    input  logic [RW-1:0] rt_i,
    input  logic [RW-1:0] rd_i,
    input  logic          eq_i,
    output logic          stall_o,
    output logic          flush_o,
    output logic          ex_ALUSrc_o,
    output logic [1:0]    ex_ALUOp_o,
    output logic          ex_RegDst_o,
    output logic [1:0]    fwdA_o,
    output logic [1:0]    fwdB_o,
    output logic          mem_MemRead_o,
    output logic          mem_MemWrite_o,
    output logic          wb_RegWrite_o,
    output logic          wb_MemToReg_o,
    output logic [RW-1:0] wb_dst_o
);

    // Branch and Jump are resolved in ID, so no later stage needs to carry them.
    logic          idexRegDst;
    logic          idexALUSrc;
    logic          idexMemToReg;
    logic          idexRegWrite;
    logic          idexMemWrite;
    logic          idexMemRead;
    logic [1:0]    idexALUOp;
    logic [RW-1:0] idexRs;
    logic [RW-1:0] idexRt;
    logic [RW-1:0] idexRd;

    logic          exmemMemRead;
    logic          exmemMemWrite;
    logic          exmemRegWrite;
    logic          exmemMemToReg;
    logic [RW-1:0] exmemDst;

    logic          memwbRegWrite;
    logic          memwbMemToReg;
    logic [RW-1:0] memwbDst;

    logic [RW-1:0] exDst;

    // Destination register is chosen in EX from the instruction format.
    assign exDst = idexRegDst ? idexRd : idexRt;

    // A load in EX whose target is read by the instruction in ID must wait one cycle.
    assign stall_o = idexMemRead & ((idexRt == rs_i) | (idexRt == rt_i));

    // A stalled branch retries next cycle; nothing redirects the PC while in reset.
    assign flush_o = rst_i & ~stall_o & (Jump_i | (Branch_i & eq_i));

    // ID/EX register: capture the decoded bundle, or a fully zeroed bubble on stall.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idexRegDst   <= 1'b0;
            idexALUSrc   <= 1'b0;
            idexMemToReg <= 1'b0;
            idexRegWrite <= 1'b0;
            idexMemWrite <= 1'b0;
            idexMemRead  <= 1'b0;
            idexALUOp    <= 2'b00;
            idexRs       <= '0;
            idexRt       <= '0;
            idexRd       <= '0;
        end else if (stall_o) begin
            idexRegDst   <= 1'b0;
            idexALUSrc   <= 1'b0;
            idexMemToReg <= 1'b0;
            idexRegWrite <= 1'b0;
            idexMemWrite <= 1'b0;
            idexMemRead  <= 1'b0;
            idexALUOp    <= 2'b00;
            idexRs       <= '0;
            idexRt       <= '0;
            idexRd       <= '0;
        end else begin
            idexRegDst   <= RegDst_i;
            idexALUSrc   <= ALUSrc_i;
            idexMemToReg <= MemToReg_i;
            idexRegWrite <= RegWrite_i;
            idexMemWrite <= MemWrite_i;
            idexMemRead  <= MemRead_i;
            idexALUOp    <= ALUOp_i;
            idexRs       <= rs_i;
            idexRt       <= rt_i;
            idexRd       <= rd_i;
        end
    end

    // EX/MEM register: advances every cycle, even while ID is stalled.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exmemMemRead  <= 1'b0;
            exmemMemWrite <= 1'b0;
            exmemRegWrite <= 1'b0;
            exmemMemToReg <= 1'b0;
            exmemDst      <= '0;
        end else begin
            exmemMemRead  <= idexMemRead;
            exmemMemWrite <= idexMemWrite;
            exmemRegWrite <= idexRegWrite;
            exmemMemToReg <= idexMemToReg;
            exmemDst      <= exDst;
        end
    end

    // MEM/WB register: carries write-back controls and destination to the last stage.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            memwbRegWrite <= 1'b0;
            memwbMemToReg <= 1'b0;
            memwbDst      <= '0;
        end else begin
            memwbRegWrite <= exmemRegWrite;
            memwbMemToReg <= exmemMemToReg;
            memwbDst      <= exmemDst;
        end
    end

    // Forwarding selects: the younger EX/MEM result wins, and $0 is never forwarded.
    always_comb begin
        fwdA_o = 2'b00;
        fwdB_o = 2'b00;
        if (exmemRegWrite && (exmemDst != '0) && (exmemDst == idexRs)) begin
            fwdA_o = 2'b10;
        end else if (memwbRegWrite && (memwbDst != '0) && (memwbDst == idexRs)) begin
            fwdA_o = 2'b01;
        end
        if (exmemRegWrite && (exmemDst != '0) && (exmemDst == idexRt)) begin
            fwdB_o = 2'b10;
        end else if (memwbRegWrite && (memwbDst != '0) && (memwbDst == idexRt)) begin
            fwdB_o = 2'b01;
        end
    end

    assign ex_ALUSrc_o    = idexALUSrc;
    assign ex_ALUOp_o     = idexALUOp;
    assign ex_RegDst_o    = idexRegDst;
    assign mem_MemRead_o  = exmemMemRead;
    assign mem_MemWrite_o = exmemMemWrite;
    assign wb_RegWrite_o  = memwbRegWrite;
    assign wb_MemToReg_o  = memwbMemToReg;
    assign wb_dst_o       = memwbDst;

endmodule

// File: tb/tb_control_pipe.sv
// Directed table-driven bench for control_pipe: each record holds one cycle's
// ID inputs and the outputs expected during that cycle, before the next edge.
module tb_control_pipe;

    // Control bundle packing: {RegDst, ALUSrc, MemToReg, RegWrite, MemWrite, MemRead, Branch, Jump, ALUOp}
    localparam logic [9:0] ctlNop = 10'b0000000000;
    localparam logic [9:0] ctlR   = 10'b1001000010;
    localparam logic [9:0] ctlLw  = 10'b0111010000;
    localparam logic [9:0] ctlSw  = 10'b0100100000;
    localparam logic [9:0] ctlBeq = 10'b0000001001;
    localparam logic [9:0] ctlJ   = 10'b0000000100;

    typedef struct {
        logic [9:0] ctrl;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       eq;
        logic       stall;
        logic       flush;
        logic [3:0] ex;
        logic [3:0] fwd;
        logic [1:0] mem;
        logic [1:0] wb;
        logic [4:0] dst;
    } vecT;

    logic       clk;
    logic       rstN;
    logic       regDst, aluSrc, memToReg, regWrite, memWrite, memRead, branch, jump;
    logic [1:0] aluOp;
    logic [4:0] rs, rt, rd;
    logic       eq;
    logic       stall, flush;
    logic       exAluSrc, exRegDst;
    logic [1:0] exAluOp;
    logic [1:0] fwdA, fwdB;
    logic       memMemRead, memMemWrite;
    logic       wbRegWrite, wbMemToReg;
    logic [4:0] wbDst;

    int checks = 0;
    int errors = 0;
    vecT vecs[21];

    control_pipe #(.RW(5)) dut (
        .clk_i(clk),
        .rst_i(rstN),
        .RegDst_i(regDst),
        .ALUSrc_i(aluSrc),
        .MemToReg_i(memToReg),
        .RegWrite_i(regWrite),
        .MemWrite_i(memWrite),
        .MemRead_i(memRead),
        .Branch_i(branch),
        .Jump_i(jump),
        .ALUOp_i(aluOp),
        .rs_i(rs),
        .rt_i(rt),
        .rd_i(rd),
        .eq_i(eq),
        .stall_o(stall),
        .flush_o(flush),
        .ex_ALUSrc_o(exAluSrc),
        .ex_ALUOp_o(exAluOp),
        .ex_RegDst_o(exRegDst),
        .fwdA_o(fwdA),
        .fwdB_o(fwdB),
        .mem_MemRead_o(memMemRead),
        .mem_MemWrite_o(memMemWrite),
        .wb_RegWrite_o(wbRegWrite),
        .wb_MemToReg_o(wbMemToReg),
        .wb_dst_o(wbDst)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vecT mk(input logic [9:0] ctrl, input logic [4:0] vRs, input logic [4:0] vRt,
                               input logic [4:0] vRd, input logic vEq, input logic vStall,
                               input logic vFlush, input logic [3:0] vEx, input logic [3:0] vFwd,
                               input logic [1:0] vMem, input logic [1:0] vWb, input logic [4:0] vDst);
        vecT v;
        v.ctrl  = ctrl;
        v.rs    = vRs;
        v.rt    = vRt;
        v.rd    = vRd;
        v.eq    = vEq;
        v.stall = vStall;
        v.flush = vFlush;
        v.ex    = vEx;
        v.fwd   = vFwd;
        v.mem   = vMem;
        v.wb    = vWb;
        v.dst   = vDst;
        return v;
    endfunction

    task automatic applyStimulus(input vecT v);
        {regDst, aluSrc, memToReg, regWrite, memWrite, memRead, branch, jump, aluOp} = v.ctrl;
        rs = v.rs;
        rt = v.rt;
        rd = v.rd;
        eq = v.eq;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkVector(input string tag, input vecT v);
        checkOutput($sformatf("%s stall", tag), {15'd0, stall}, {15'd0, v.stall});
        checkOutput($sformatf("%s flush", tag), {15'd0, flush}, {15'd0, v.flush});
        checkOutput($sformatf("%s ex", tag), {12'd0, exAluSrc, exAluOp, exRegDst}, {12'd0, v.ex});
        checkOutput($sformatf("%s fwd", tag), {12'd0, fwdA, fwdB}, {12'd0, v.fwd});
        checkOutput($sformatf("%s mem", tag), {14'd0, memMemRead, memMemWrite}, {14'd0, v.mem});
        checkOutput($sformatf("%s wb", tag), {14'd0, wbRegWrite, wbMemToReg}, {14'd0, v.wb});
        checkOutput($sformatf("%s dst", tag), {11'd0, wbDst}, {11'd0, v.dst});
    endtask

    // Drive one cycle: inputs change on the falling edge, outputs are checked before the rise.
    task automatic runCycle(input string tag, input vecT v);
        @(negedge clk);
        applyStimulus(v);
        #2;
        checkVector(tag, v);
    endtask

    // Main sequence: reset, the directed table, then hand-written reset corner cases.
    initial begin
        vecT zeroNop;
        vecT jumpIn;
        vecT v;

        zeroNop = mk(ctlNop, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 2'b00, 0);
        jumpIn  = mk(ctlJ, 3, 4, 0, 1, 0, 0, 4'b0000, 4'b0000, 2'b00, 2'b00, 0);

        //               ctrl    rs  rt  rd eq | st fl ex       fwd      mem    wb     dst
        vecs[0]  = mk(ctlLw,   2,  9,  0, 0,   0, 0, 4'b0000, 4'b0000, 2'b00, 2'b00, 0);
        vecs[1]  = mk(ctlR,    9,  3, 10, 0,   1, 0, 4'b1000, 4'b0000, 2'b00, 2'b00, 0);
        vecs[2]  = mk(ctlR,    9,  3, 10, 0,   0, 0, 4'b0000, 4'b0000, 2'b10, 2'b00, 0);
        vecs[3]  = mk(ctlR,   10,  9, 11, 0,   0, 0, 4'b0101, 4'b0100, 2'b00, 2'b11, 9);
        vecs[4]  = mk(ctlR,    1,  2,  7, 0,   0, 0, 4'b0101, 4'b1000, 2'b00, 2'b00, 0);
        vecs[5]  = mk(ctlR,    3,  4,  7, 0,   0, 0, 4'b0101, 4'b0000, 2'b00, 2'b10, 10);
        vecs[6]  = mk(ctlR,    0,  7, 12, 0,   0, 0, 4'b0101, 4'b0000, 2'b00, 2'b10, 11);
        vecs[7]  = mk(ctlNop,  0,  0,  0, 0,   0, 0, 4'b0101, 4'b0010, 2'b00, 2'b10, 7);
        vecs[8]  = mk(ctlR,    0,  0,  0, 0,   0, 0, 4'b0000, 4'b0000, 2'b00, 2'b10, 7);
        vecs[9]  = mk(ctlR,    0,  5,  0, 0,   0, 0, 4'b0101, 4'b0000, 2'b00, 2'b10, 12);
        vecs[10] = mk(ctlNop,  0,  0,  0, 0,   0, 0, 4'b0101, 4'b0000, 2'b00, 2'b00, 0);
        vecs[11] = mk(ctlNop,  0,  0,  0, 0,   0, 0, 4'b0000, 4'b0000, 2'b00, 2'b10, 0);
        vecs[12] = mk(ctlBeq,  4,  5,  0, 1,   0, 1, 4'b0000, 4'b0000, 2'b00, 2'b10, 0);
        vecs[13] = mk(ctlJ,    0,  0,  0, 0,   0, 1, 4'b0010, 4'b0000, 2'b00, 2'b00, 0);
        vecs[14] = mk(ctlNop,  0,  0,  0, 0,   0, 0, 4'b0000, 4'b0000, 2'b00, 2'b00, 0);
        vecs[15] = mk(ctlNop,  0,  0,  0, 0,   0, 0, 4'b0000, 4'b0000, 2'b00, 2'b00, 5);
        vecs[16] = mk(ctlLw,   1,  8,  0, 0,   0, 0, 4'b0000, 4'b0000, 2'b00, 2'b00, 0);
        vecs[17] = mk(ctlBeq,  8,  2,  0, 1,   1, 0, 4'b1000, 4'b0000, 2'b00, 2'b00, 0);
        vecs[18] = mk(ctlBeq,  8,  2,  0, 1,   0, 1, 4'b0000, 4'b0000, 2'b10, 2'b00, 0);
        vecs[19] = mk(ctlSw,   2,  8,  0, 0,   0, 0, 4'b0010, 4'b0100, 2'b00, 2'b11, 8);
        vecs[20] = mk(ctlNop,  0,  0,  0, 0,   0, 0, 4'b1000, 4'b0000, 2'b00, 2'b00, 0);

        // Power-on reset: a jump on the inputs must not raise flush while in reset.
        rstN = 1'b0;
        applyStimulus(jumpIn);
        #2;
        checkVector("por", zeroNop);
        repeat (2) @(negedge clk);
        applyStimulus(zeroNop);
        rstN = 1'b1;

        for (int i = 0; i < 21; i++) begin
            runCycle($sformatf("vec%0d", i), vecs[i]);
        end

        // sw sits in EX/MEM now; an async reset must clear MemWrite without a clock edge.
        v = mk(ctlNop, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 2'b01, 2'b00, 2);
        runCycle("swInMem", v);
        rstN = 1'b0;
        #1;
        checkVector("asyncReset", zeroNop);
        applyStimulus(jumpIn);
        #1;
        checkVector("resetJump", zeroNop);
        repeat (2) @(negedge clk);
        applyStimulus(zeroNop);
        rstN = 1'b1;

        // After release nothing leaks out until a new instruction propagates.
        for (int i = 0; i < 3; i++) begin
            runCycle($sformatf("postReset%0d", i), zeroNop);
        end
        runCycle("newInstId", mk(ctlR, 1, 2, 3, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 2'b00, 0));
        runCycle("newInstEx", mk(ctlNop, 0, 0, 0, 0, 0, 0, 4'b0101, 4'b0000, 2'b00, 2'b00, 0));
        runCycle("newInstMem", zeroNop);
        runCycle("newInstWb", mk(ctlNop, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 2'b10, 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
